// File: rtl/axi4_axch_sender_q.sv
// AXI4 address-channel sender with L1 pass-through and an L2 miss queue.
// Optional miss queue and L2 path enabled by defining AXCH_SENDER_L2Q_EN.
module axi4_axch_sender_q #(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_USER_WIDTH = 4,
    parameter int C_ADDR_WIDTH     = 32,
    parameter int L2_Q_DEPTH       = 4
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arstn,
    input  logic                        l1_trans_accept,
    input  logic                        l1_trans_drop,
    output logic                        l1_trans_sent,
    input  logic                        l2_trans_accept,
    input  logic                        l2_trans_drop,
    output logic                        l2_trans_sent,
    output logic                        l2_q_full,
    output logic                        l2_q_empty,
    input  logic                        stall,
    input  logic [C_ADDR_WIDTH-1:0]     l1_axi4_axaddr,
    input  logic [C_ADDR_WIDTH-1:0]     l2_axi4_axaddr,
    input  logic                        s_axi4_axvalid,
    output logic                        s_axi4_axready,
    input  logic [C_AXI_ID_WIDTH-1:0]   s_axi4_axid,
    input  logic [7:0]                  s_axi4_axlen,
    input  logic [2:0]                  s_axi4_axsize,
    input  logic [1:0]                  s_axi4_axburst,
    input  logic                        s_axi4_axlock,
    input  logic [2:0]                  s_axi4_axprot,
    input  logic [3:0]                  s_axi4_axcache,
    input  logic [3:0]                  s_axi4_axregion,
    input  logic [3:0]                  s_axi4_axqos,
    input  logic [C_AXI_USER_WIDTH-1:0] s_axi4_axuser,
    output logic                        m_axi4_axvalid,
    input  logic                        m_axi4_axready,
    output logic [C_ADDR_WIDTH-1:0]     m_axi4_axaddr,
    output logic [C_AXI_ID_WIDTH-1:0]   m_axi4_axid,
    output logic [7:0]                  m_axi4_axlen,
    output logic [2:0]                  m_axi4_axsize,
    output logic [1:0]                  m_axi4_axburst,
    output logic                        m_axi4_axlock,
    output logic [2:0]                  m_axi4_axprot,
    output logic [3:0]                  m_axi4_axcache,
    output logic [3:0]                  m_axi4_axregion,
    output logic [3:0]                  m_axi4_axqos,
    output logic [C_AXI_USER_WIDTH-1:0] m_axi4_axuser
);

    typedef struct packed {
        logic [C_AXI_ID_WIDTH-1:0]   id;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic                        lock;
        logic [2:0]                  prot;
        logic [3:0]                  cache;
        logic [3:0]                  region;
        logic [3:0]                  qos;
        logic [C_AXI_USER_WIDTH-1:0] user;
    } ax_t;

    logic                    r_l1_pend;
    logic                    r_wait_stall;
    logic                    w_l2_send;
    logic                    w_drop_ok;
    logic                    w_l1_req;
    logic                    w_m_valid;
    logic                    w_m_hs;
    logic                    w_l1_hs;
    logic                    w_get_new;
    logic                    w_s_ready;
    ax_t                     w_s_ax;
    ax_t                     w_m_ax;
    logic [C_ADDR_WIDTH-1:0] w_m_addr;

    assign w_s_ax = {s_axi4_axid, s_axi4_axlen, s_axi4_axsize,
                     s_axi4_axburst, s_axi4_axlock, s_axi4_axprot,
                     s_axi4_axcache, s_axi4_axregion, s_axi4_axqos,
                     s_axi4_axuser};

`ifdef AXCH_SENDER_L2Q_EN
    localparam int PW = $clog2(L2_Q_DEPTH);
    localparam logic [PW:0] QD = (PW+1)'(L2_Q_DEPTH);

    ax_t           r_q [L2_Q_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_cnt;
    logic          r_l2_send;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_l2_hs;

    assign w_full    = (r_cnt == QD);
    assign w_empty   = (r_cnt == '0);
    assign w_l2_send = r_l2_send;
    assign w_l2_hs   = w_m_hs & r_l2_send;
    assign w_drop_ok = s_axi4_axvalid & l1_trans_drop & ~w_full;
    assign w_push    = w_drop_ok;
    assign w_pop     = w_l2_hs |
                       (l2_trans_drop & ~w_empty & ~r_l2_send);
    assign w_m_ax    = r_l2_send ? r_q[r_rd_ptr] : w_s_ax;
    assign w_m_addr  = r_l2_send ? l2_axi4_axaddr : l1_axi4_axaddr;

    assign l2_trans_sent = w_l2_hs & axi4_arstn;
    assign l2_q_full     = w_full;
    assign l2_q_empty    = w_empty;

    // L2 send flag: armed by an L2 hit on a non-empty queue, dropped on handshake
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_l2_send <= 1'b0;
        end else if (w_l2_hs) begin
            r_l2_send <= 1'b0;
        end else if (l2_trans_accept && !w_empty) begin
            r_l2_send <= 1'b1;
        end
    end

    // Miss queue storage, pointers and occupancy
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            for (int i = 0; i < L2_Q_DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_q[r_wr_ptr] <= w_s_ax;
                r_wr_ptr      <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
`else
    logic w_unused;

    assign w_unused  = ^{l2_trans_accept, l2_trans_drop, l2_axi4_axaddr};
    assign w_l2_send = 1'b0;
    assign w_drop_ok = s_axi4_axvalid & l1_trans_drop;
    assign w_m_ax    = w_s_ax;
    assign w_m_addr  = l1_axi4_axaddr;

    assign l2_trans_sent = 1'b0;
    assign l2_q_full     = 1'b0;
    assign l2_q_empty    = 1'b1;
`endif

    assign w_l1_req  = s_axi4_axvalid & (l1_trans_accept | r_l1_pend);
    assign w_m_valid = w_l2_send | w_l1_req;
    assign w_m_hs    = w_m_valid & m_axi4_axready;
    assign w_l1_hs   = w_m_hs & ~w_l2_send;
    assign w_get_new = w_l1_hs | w_drop_ok;
    assign w_s_ready = (w_get_new | r_wait_stall) & ~stall;

    assign m_axi4_axvalid = w_m_valid & axi4_arstn;
    assign s_axi4_axready = w_s_ready & axi4_arstn;
    assign l1_trans_sent  = s_axi4_axvalid & s_axi4_axready;
    assign m_axi4_axaddr  = w_m_addr;

    assign {m_axi4_axid, m_axi4_axlen, m_axi4_axsize, m_axi4_axburst,
            m_axi4_axlock, m_axi4_axprot, m_axi4_axcache,
            m_axi4_axregion, m_axi4_axqos, m_axi4_axuser} = w_m_ax;

    // L1 pending and stall-deferred slave ready; clear wins over set
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_l1_pend    <= 1'b0;
            r_wait_stall <= 1'b0;
        end else begin
            if (w_l1_hs) begin
                r_l1_pend <= 1'b0;
            end else if (l1_trans_accept) begin
                r_l1_pend <= 1'b1;
            end
            if (w_s_ready) begin
                r_wait_stall <= 1'b0;
            end else if (w_get_new && stall) begin
                r_wait_stall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4_axch_sender_q.sv
// Directed bench for axi4_axch_sender_q with a queue-based reference model.
// Covers the L2 miss-queue scenarios when AXCH_SENDER_L2Q_EN is defined.
module tb_axi4_axch_sender_q;

`ifdef AXCH_SENDER_L2Q_EN
    localparam bit L2EN = 1'b1;
`else
    localparam bit L2EN = 1'b0;
`endif

    typedef logic [36:0] bun_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        l1_acc, l1_drop, l1_sent;
    logic        l2_acc, l2_drop, l2_sent;
    logic        q_full, q_empty, stall;
    logic [31:0] l1_addr, l2_addr, m_addr;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [3:0]  s_id, m_id;
    logic [7:0]  s_len, m_len;
    logic [2:0]  s_size, m_size;
    logic [1:0]  s_burst, m_burst;
    logic        s_lock, m_lock;
    logic [2:0]  s_prot, m_prot;
    logic [3:0]  s_cache, m_cache;
    logic [3:0]  s_region, m_region;
    logic [3:0]  s_qos, m_qos;
    logic [3:0]  s_user, m_user;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi4_axch_sender_q dut (
        .axi4_aclk       (clk),
        .axi4_arstn      (rst_n),
        .l1_trans_accept (l1_acc),
        .l1_trans_drop   (l1_drop),
        .l1_trans_sent   (l1_sent),
        .l2_trans_accept (l2_acc),
        .l2_trans_drop   (l2_drop),
        .l2_trans_sent   (l2_sent),
        .l2_q_full       (q_full),
        .l2_q_empty      (q_empty),
        .stall           (stall),
        .l1_axi4_axaddr  (l1_addr),
        .l2_axi4_axaddr  (l2_addr),
        .s_axi4_axvalid  (s_valid),
        .s_axi4_axready  (s_ready),
        .s_axi4_axid     (s_id),
        .s_axi4_axlen    (s_len),
        .s_axi4_axsize   (s_size),
        .s_axi4_axburst  (s_burst),
        .s_axi4_axlock   (s_lock),
        .s_axi4_axprot   (s_prot),
        .s_axi4_axcache  (s_cache),
        .s_axi4_axregion (s_region),
        .s_axi4_axqos    (s_qos),
        .s_axi4_axuser   (s_user),
        .m_axi4_axvalid  (m_valid),
        .m_axi4_axready  (m_ready),
        .m_axi4_axaddr   (m_addr),
        .m_axi4_axid     (m_id),
        .m_axi4_axlen    (m_len),
        .m_axi4_axsize   (m_size),
        .m_axi4_axburst  (m_burst),
        .m_axi4_axlock   (m_lock),
        .m_axi4_axprot   (m_prot),
        .m_axi4_axcache  (m_cache),
        .m_axi4_axregion (m_region),
        .m_axi4_axqos    (m_qos),
        .m_axi4_axuser   (m_user)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference model: transaction-level state plus a queue of miss bundles
    bun_t mq[$];
    bit   md_pend, md_sending, md_waiting;

    always @(negedge clk) begin : model
        bun_t        sb, eb, gb;
        logic [31:0] ea;
        bit          full, empty, l1req, mv, l1go, l2go, take, sr;
        bit          pop, push, e_l1s, e_l2s;
        sb = {s_id, s_len, s_size, s_burst, s_lock, s_prot,
              s_cache, s_region, s_qos, s_user};
        gb = {m_id, m_len, m_size, m_burst, m_lock, m_prot,
              m_cache, m_region, m_qos, m_user};
        if (!rst_n) begin
            mq.delete();
            md_pend = 0; md_sending = 0; md_waiting = 0;
            full = 0; empty = 1; mv = 0; sr = 0;
            e_l1s = 0; e_l2s = 0; eb = sb; ea = l1_addr;
            l1go = 0; l2go = 0; take = 0;
        end else begin
            full  = L2EN && (mq.size() == 4);
            empty = !L2EN || (mq.size() == 0);
            l1req = s_valid && (l1_acc || md_pend);
            mv    = md_sending || l1req;
            l1go  = l1req && !md_sending && m_ready;
            l2go  = md_sending && m_ready;
            take  = l1go || (s_valid && l1_drop && !full);
            sr    = (take || md_waiting) && !stall;
            e_l1s = s_valid && sr;
            e_l2s = l2go;
            eb    = md_sending ? mq[0] : sb;
            ea    = md_sending ? l2_addr : l1_addr;
        end
        chk("mvalid", {63'd0, m_valid}, {63'd0, mv});
        chk("sready", {63'd0, s_ready}, {63'd0, sr});
        chk("l1sent", {63'd0, l1_sent}, {63'd0, e_l1s});
        chk("l2sent", {63'd0, l2_sent}, {63'd0, e_l2s});
        chk("qfull", {63'd0, q_full}, {63'd0, full});
        chk("qempty", {63'd0, q_empty}, {63'd0, empty});
        if (mv) begin
            chk("mattr", {27'd0, gb}, {27'd0, eb});
            chk("maddr", {32'd0, m_addr}, {32'd0, ea});
        end
        if (rst_n) begin
            pop  = L2EN && (l2go || (l2_drop && !empty && !md_sending));
            push = L2EN && s_valid && l1_drop && !full;
            if (l2go) md_sending = 0;
            else if (L2EN && l2_acc && !empty) md_sending = 1;
            if (l1go) md_pend = 0;
            else if (l1_acc) md_pend = 1;
            if (sr) md_waiting = 0;
            else if (take && stall) md_waiting = 1;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(sb);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_attr(input logic [3:0] id);
        s_id = id;
        s_len = {id, ~id};
        s_size = id[2:0];
        s_burst = id[1:0] ^ 2'b01;
        s_lock = id[0];
        s_prot = ~id[2:0];
        s_cache = id + 4'd1;
        s_region = id ^ 4'h5;
        s_qos = ~id;
        s_user = id + 4'd7;
    endtask

    task automatic idle();
        l1_acc = 0; l1_drop = 0; l2_acc = 0; l2_drop = 0;
        stall = 0; s_valid = 0; m_ready = 0;
        l1_addr = 32'h0; l2_addr = 32'h0;
        set_attr(4'h0);
    endtask

    int vcnt, rcnt;

    initial begin
        idle();
        rst_n = 0;
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_empty", {63'd0, q_empty}, 64'd1);
        chk("rst_mvalid", {63'd0, m_valid}, 64'd0);
        cyc();
        rst_n = 1;
        cyc();

        // Single L1 hit with master ready: everything in one cycle
        s_valid = 1; l1_acc = 1; m_ready = 1;
        set_attr(4'h2); l1_addr = 32'h2000;
        @(negedge clk);
        chk("hit_mvalid", {63'd0, m_valid}, 64'd1);
        chk("hit_sready", {63'd0, s_ready}, 64'd1);
        chk("hit_l1sent", {63'd0, l1_sent}, 64'd1);
        chk("hit_addr", {32'd0, m_addr}, 64'h2000);
        cyc(); idle(); cyc();

        // L1 hit with master back-pressure for 3 cycles
        s_valid = 1; l1_acc = 1; m_ready = 0;
        set_attr(4'h5); l1_addr = 32'h1000;
        vcnt = 0; rcnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) m_ready = 1;
            @(negedge clk);
            if (m_valid) vcnt++;
            if (s_ready) begin
                rcnt++;
                chk("bp_ready_cyc", 64'(c), 64'd3);
            end
            chk("bp_addr", {32'd0, m_addr}, 64'h1000);
            cyc();
            l1_acc = 0;
        end
        chk("bp_valid_cycles", 64'(vcnt), 64'd4);
        chk("bp_ready_pulses", 64'(rcnt), 64'd1);
        idle();
        @(negedge clk);
        chk("bp_done", {63'd0, m_valid}, 64'd0);
        cyc();

        // Handshake under stall: ready deferred until stall drops
        s_valid = 1; l1_acc = 1; m_ready = 1; stall = 1;
        set_attr(4'h6); l1_addr = 32'h1100;
        @(negedge clk);
        chk("st_sready0", {63'd0, s_ready}, 64'd0);
        cyc();
        l1_acc = 0;
        @(negedge clk);
        chk("st_sready1", {63'd0, s_ready}, 64'd0);
        chk("st_wait", {63'd0, dut.r_wait_stall}, 64'd1);
        cyc();
        stall = 0;
        @(negedge clk);
        chk("st_pulse", {63'd0, s_ready}, 64'd1);
        chk("st_l1sent", {63'd0, l1_sent}, 64'd1);
        cyc();
        @(negedge clk);
        chk("st_single", {63'd0, s_ready}, 64'd0);
        cyc(); idle(); cyc();

`ifdef AXCH_SENDER_L2Q_EN
        // Fill the queue with four drops; the fifth waits for a pop
        l2_acc = 1;
        @(negedge clk);
        chk("l2acc_empty", {63'd0, m_valid}, 64'd0);
        cyc(); l2_acc = 0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; l1_drop = 1; set_attr(4'(i + 1));
            @(negedge clk);
            chk("fill_ready", {63'd0, s_ready}, 64'd1);
            cyc();
        end
        set_attr(4'h5);
        @(negedge clk);
        chk("fill_full", {63'd0, q_full}, 64'd1);
        chk("fill_block0", {63'd0, s_ready}, 64'd0);
        cyc();
        @(negedge clk);
        chk("fill_block1", {63'd0, s_ready}, 64'd0);
        cyc();
        l2_drop = 1;
        @(negedge clk);
        chk("fill_block2", {63'd0, s_ready}, 64'd0);
        cyc();
        l2_drop = 0;
        @(negedge clk);
        chk("fill_fifth", {63'd0, s_ready}, 64'd1);
        cyc(); idle();
        l2_drop = 1;
        cyc();
        l2_drop = 0;

        // Head id=3: L2 and L1 accepted together, L2 goes first
        s_valid = 1; l1_acc = 1; set_attr(4'h9);
        l1_addr = 32'h3000; l2_addr = 32'h8000;
        l2_acc = 1; m_ready = 0;
        @(negedge clk);
        chk("arb_l2sent0", {63'd0, l2_sent}, 64'd0);
        cyc();
        l1_acc = 0; l2_acc = 0; m_ready = 1;
        @(negedge clk);
        chk("arb_l2_id", {60'd0, m_id}, 64'd3);
        chk("arb_l2_addr", {32'd0, m_addr}, 64'h8000);
        chk("arb_l2sent", {63'd0, l2_sent}, 64'd1);
        chk("arb_l1wait", {63'd0, l1_sent}, 64'd0);
        cyc();
        @(negedge clk);
        chk("arb_l1_id", {60'd0, m_id}, 64'd9);
        chk("arb_l1_addr", {32'd0, m_addr}, 64'h3000);
        chk("arb_l1sent", {63'd0, l1_sent}, 64'd1);
        cyc(); idle();

        // Reset while two entries are queued and L2 is sending
        l2_acc = 1;
        cyc();
        l2_acc = 0;
        @(negedge clk);
        chk("rq_sending", {63'd0, m_valid}, 64'd1);
        cyc();
        rst_n = 0;
        #1;
        chk("rq_mvalid", {63'd0, m_valid}, 64'd0);
        chk("rq_empty", {63'd0, q_empty}, 64'd1);
        cyc(); cyc();
        rst_n = 1;
        cyc();
        @(negedge clk);
        chk("rq_noreplay", {63'd0, m_valid}, 64'd0);
        cyc();
`else
        // Without the queue every drop is taken and L2 inputs do nothing
        for (int i = 0; i < 5; i++) begin
            s_valid = 1; l1_drop = 1; set_attr(4'(i + 1));
            l2_acc = i[0]; l2_drop = ~i[0]; l2_addr = 32'h8000;
            @(negedge clk);
            chk("drop_ready", {63'd0, s_ready}, 64'd1);
            chk("drop_empty", {63'd0, q_empty}, 64'd1);
            chk("drop_l2sent", {63'd0, l2_sent}, 64'd0);
            cyc();
        end
        idle(); cyc();
`endif

        // Reset while an L1 request is pending; it must not be replayed
        s_valid = 1; l1_acc = 1; m_ready = 0;
        set_attr(4'hA); l1_addr = 32'h4000;
        cyc();
        l1_acc = 0;
        @(negedge clk);
        chk("rp_pending", {63'd0, m_valid}, 64'd1);
        cyc();
        rst_n = 0;
        #1;
        chk("rp_mvalid", {63'd0, m_valid}, 64'd0);
        cyc();
        rst_n = 1;
        cyc();
        @(negedge clk);
        chk("rp_noreplay", {63'd0, m_valid}, 64'd0);
        cyc(); idle(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
